// File: rtl/xor_frame_checksum.sv
// Frame-level XOR checksum: folds WIDTH-bit words between in_last delimiters and
// holds the checksum, its parity, the saturating beat count and an overflow flag.
module xor_frame_checksum #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_parity,
    output logic [LEN_W-1:0] out_len,
    output logic             out_overflow
);

    // Handshakes: a beat moves when in_valid && in_ready at a rising edge, a
    // result moves when out_valid && out_ready; both sides use plain valid/ready.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_e;

    localparam logic [LEN_W-1:0] CNT_MAX = '1;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovf_out_q, ovf_out_d;

    logic               accept;
    logic               consume;
    logic               at_max;
    logic [WIDTH-1:0]   acc_next;
    logic [LEN_W-1:0]   cnt_next;
    logic               ovf_next;

    assign accept  = in_valid && in_ready;
    assign consume = out_valid && out_ready;

    // acc/cnt/ovf are zero in IDLE, so the same fold covers a frame's first beat.
    assign at_max   = (cnt_q == CNT_MAX);
    assign acc_next = acc_q ^ in_data;
    assign cnt_next = at_max ? cnt_q : cnt_q + LEN_W'(1);
    assign ovf_next = ovf_q | at_max;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            sum_q     <= '0;
            len_q     <= '0;
            ovf_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            sum_q     <= sum_d;
            len_q     <= len_d;
            ovf_out_q <= ovf_out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_ACCUM: begin
                if (accept) begin
                    state_d = in_last ? S_HOLD : S_ACCUM;
                end
            end
            S_HOLD: begin
                if (consume) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q != S_HOLD);
        out_valid = (state_q == S_HOLD);
    end

    // Result registers only load on the last beat, so they stay put through HOLD
    // and after consume.
    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        sum_d     = sum_q;
        len_d     = len_q;
        ovf_out_d = ovf_out_q;
        if (accept) begin
            if (in_last) begin
                sum_d     = acc_next;
                len_d     = cnt_next;
                ovf_out_d = ovf_next;
            end else begin
                acc_d = acc_next;
                cnt_d = cnt_next;
                ovf_d = ovf_next;
            end
        end
        if (consume) begin
            acc_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end
    end

    assign out_sum      = sum_q;
    assign out_parity   = ^sum_q;
    assign out_len      = len_q;
    assign out_overflow = ovf_out_q;

endmodule

// File: tb/tb_xor_frame_checksum.sv
// Directed bench for xor_frame_checksum (WIDTH=8, LEN_W=3): expected results are
// queued when a frame is issued and popped by a monitor on each consumed result.
module tb_xor_frame_checksum;
    localparam int WIDTH = 8;
    localparam int LEN_W = 3;
    localparam int RW    = WIDTH + 1 + LEN_W + 1;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_parity;
    logic [LEN_W-1:0] out_len;
    logic             out_overflow;

    logic [RW-1:0] exp_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            n_pops   = 0;

    xor_frame_checksum #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sum     (out_sum),
        .out_parity  (out_parity),
        .out_len     (out_len),
        .out_overflow(out_overflow)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [RW-1:0] pack(input logic [WIDTH-1:0] s, input logic p,
                                           input logic [LEN_W-1:0] l, input logic o);
        return {s, p, l, o};
    endfunction

    // Driver: called just after a rising edge; returns one edge after acceptance.
    task automatic send_beat(input logic [WIDTH-1:0] d, input logic l, output int waits);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        waits    = 0;
        while (!in_ready && waits < 50) begin
            @(posedge clk); #1;
            waits++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready=0 expected 1 within 50 cycles");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = WIDTH'($urandom_range(0, 255));
        in_last  = 1'($urandom_range(0, 1));
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            n_pops++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got sum=0x%0h with empty queue", out_sum);
            end else begin
                check("result{sum,par,len,ovf}",
                      32'(pack(out_sum, out_parity, out_len, out_overflow)),
                      32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        int w;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;

        // 1. reset
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_sum", 32'(out_sum), 32'h00);
        check("reset_out_len", 32'(out_len), 32'd0);
        check("reset_out_overflow", 32'(out_overflow), 32'd0);
        check("reset_out_parity", 32'(out_parity), 32'd0);

        // 2. three-beat frame
        exp_q.push_back(pack(8'hCC, 1'b0, 3'd3, 1'b0));
        send_beat(8'h0F, 1'b0, w);
        send_beat(8'hF0, 1'b0, w);
        send_beat(8'h33, 1'b1, w);
        check("t2_out_valid_latency", 32'(out_valid), 32'd1);
        check("t2_in_ready_hold", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check("t2_out_valid_drop", 32'(out_valid), 32'd0);
        check("t2_in_ready_back", 32'(in_ready), 32'd1);
        check("t2_sum_kept", 32'(out_sum), 32'hCC);

        // 3. back-to-back single-beat frames
        exp_q.push_back(pack(8'h01, 1'b1, 3'd1, 1'b0));
        exp_q.push_back(pack(8'hA5, 1'b0, 3'd1, 1'b0));
        send_beat(8'h01, 1'b1, w);
        send_beat(8'hA5, 1'b1, w);
        check("t3_second_beat_wait", 32'(w), 32'd1);
        @(posedge clk); #1;

        // 4. backpressure
        out_ready = 1'b0;
        exp_q.push_back(pack(8'h26, 1'b1, 3'd2, 1'b0));
        send_beat(8'h12, 1'b0, w);
        send_beat(8'h34, 1'b1, w);
        in_valid = 1'b1; in_data = 8'h77; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("t4_in_ready_blocked", 32'(in_ready), 32'd0);
            check("t4_stable{sum,par,len,ovf,vld}",
                  32'({out_sum, out_parity, out_len, out_overflow, out_valid}),
                  32'({8'h26, 1'b1, 3'd2, 1'b0, 1'b1}));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        exp_q.push_back(pack(8'h77, 1'b0, 3'd1, 1'b0));
        send_beat(8'h77, 1'b1, w);
        check("t4_0x77_wait", 32'(w), 32'd1);
        @(posedge clk); #1;

        // 5. length overflow at LEN_W=3
        exp_q.push_back(pack(8'h01, 1'b1, 3'd7, 1'b1));
        for (int i = 0; i < 9; i++) send_beat(8'h01, (i == 8), w);
        exp_q.push_back(pack(8'h02, 1'b1, 3'd1, 1'b0));
        send_beat(8'h02, 1'b1, w);
        @(posedge clk); #1;

        // 6. reset mid-frame
        send_beat(8'hAA, 1'b0, w);
        send_beat(8'h0F, 1'b0, w);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t6_post_reset_sum", 32'(out_sum), 32'h00);
        check("t6_post_reset_ready", 32'(in_ready), 32'd1);
        exp_q.push_back(pack(8'h55, 1'b0, 3'd1, 1'b0));
        send_beat(8'h55, 1'b1, w);
        repeat (3) @(posedge clk);
        #1;

        check("results_consumed", 32'(n_pops), 32'd8);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/xor_frame_checksum.md
Name: xor_frame_checksum

Overview:
Parametrised, clocked successor to our single-bit XOR gate. Folds a stream of WIDTH-bit words into a running bitwise-XOR checksum over a frame delimited by in_last. It reports the checksum, its reduction parity, the frame length and a length-overflow flag. It sits between a word-stream source and a consumer, with valid/ready handshakes on both sides.

Parameters:
WIDTH, 8, data word and checksum width in bits (>=1).
LEN_W, 5, frame-length counter width; maximum reportable length is 2^LEN_W-1.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous active-high reset.
in_valid  input  1  input beat offered.
in_ready  output  1  block can accept a beat this cycle.
in_data  input  WIDTH  input word.
in_last  input  1  beat is the final word of its frame.
out_valid  output  1  result held on out_* ports.
out_ready  input  1  consumer accepts the result.
out_sum  output  WIDTH  XOR of all words in the frame.
out_parity  output  1  reduction XOR of out_sum.
out_len  output  LEN_W  beats in frame, saturating.
out_overflow  output  1  frame exceeded 2^LEN_W-1 beats.

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high. rst has priority over every other event.
- Reset state is IDLE:
  - in_ready=1, out_valid=0.
  - out_sum=0, out_parity=0, out_len=0, out_overflow=0.
  - Internal accumulator=0, internal count=0, overflow flag=0.
- A beat is accepted when in_valid && in_ready at a rising edge. A result is consumed when out_valid && out_ready.
- FSM states:
  - IDLE (acc=0, cnt=0): in_ready=1. Accepted beat with in_last=0 -> ACCUM, acc=in_data, cnt=1. Accepted beat with in_last=1 -> HOLD.
  - ACCUM: in_ready=1. Each accepted beat sets acc ^= in_data and increments cnt. cnt saturates at 2^LEN_W-1; an increment attempted at saturation sets the sticky ovf flag. Accepted beat with in_last=1 -> HOLD.
  - HOLD: in_ready=0 and out_valid=1. On consume -> IDLE, with acc, cnt and ovf cleared.
- Entering HOLD, on the edge that accepts the last beat:
  - out_sum = acc ^ in_data (acc taken as 0 from IDLE).
  - out_len = saturated cnt+1.
  - out_overflow = ovf, or set if this last beat itself would exceed saturation.
  - out_parity = ^out_sum.
- Latency: out_valid rises on the edge that accepts the last beat, i.e. one cycle after that beat is presented.
- out_* are stable throughout HOLD regardless of out_ready.
- out_* keep their last values after consume; only out_valid drops.
- Throughput: at most one frame per (frame length + 1) cycles with out_ready held high, because HOLD always costs at least one cycle.
- Input offered while in HOLD is not accepted. The source must hold it until in_ready returns.
- in_valid=0 in ACCUM leaves acc and cnt unchanged, with no timeout.
- in_data and in_last are ignored when not accepted.
- rst mid-frame or in HOLD discards the partial or pending result and returns to the reset state on that edge.
- WIDTH=1 degenerates to a clocked serial XOR and parity of a bitstream.

Test Plan:
1. Reset with rst=1 for 2 cycles, then rst=0 -> in_ready=1, out_valid=0, out_sum=0x00, out_len=0, out_overflow=0.
2. WIDTH=8, out_ready=1: beats 0x0F, 0xF0, 0x33(last) on consecutive cycles -> out_valid=1 the next cycle for 1 cycle, out_sum=0xCC, out_parity=0, out_len=3, out_overflow=0, and in_ready=0 for exactly that cycle.
3. Single-beat frames back-to-back: 0x01(last) then 0xA5(last), out_ready=1.
   - First frame -> out_sum=0x01, parity=1, len=1.
   - Second beat is held off one cycle by in_ready=0, then -> out_sum=0xA5, parity=0, len=1.
4. Backpressure: frame 0x12, 0x34(last) with out_ready=0 for 5 cycles while in_valid=1 offers 0x77.
   - out_sum=0x26, parity=1, len=2 stay stable; in_ready=0 and 0x77 is not accepted.
   - Raise out_ready -> IDLE next cycle, then 0x77 is accepted.
5. Overflow with LEN_W=3: nine beats of 0x01, last on the 9th -> out_sum=0x01, out_len=7, out_overflow=1. The following frame 0x02(last) -> out_overflow=0, len=1.
6. Reset mid-frame: 0xAA, 0x0F accepted, rst pulsed one cycle, then 0x55(last) -> out_sum=0x55, out_len=1, with no contribution from the discarded beats.
